// File: rtl/hashgen_pkg.sv
// hashgen_pkg -- shared definitions for the hash block controller.
//   state_t    : controller state encoding
//   CTL_*      : 2-bit datapath register commands ({R8,R9} / {R10,R11})
//   NWORDS_DEF : default number of words per hash block
package hashgen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_GO,
        S_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    // Register command codes: clear, increment, hold (low bit ignored on hold)
    localparam logic [1:0] CTL_CLR  = 2'b00;
    localparam logic [1:0] CTL_INC  = 2'b01;
    localparam logic [1:0] CTL_HOLD = 2'b10;

    localparam int NWORDS_DEF = 16;

endpackage

// File: rtl/hashgen_ctrl.sv
// hashgen_ctrl -- sequences word loading, compression and block stepping
// for a multi-block hash job. The sw (word select) and counter (block
// index) registers live in the datapath one level up; this block only
// issues clear/increment/hold commands to them and reads them back.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, nblocks    job request (sampled in IDLE); nblocks 0 means 1
//   sw, counter       fed-back datapath registers
//   R8, R9            sw command       {00 clear, 01 inc, 1x hold}
//   R10, R11          counter command  (same encoding)
//   word_valid        word at index sw offered to the core
//   word_ready        core accepts the offered word
//   blk_go            one-cycle pulse: block loaded, start compression
//   core_done         core finished the current block
//   busy              high outside IDLE
//   done              one-cycle pulse: job complete
module hashgen_ctrl
    import hashgen_pkg::*;
#(
    parameter int NWORDS = NWORDS_DEF,
    parameter int NBLK_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NBLK_W-1:0] nblocks,
    input  logic [4:0]        sw,
    input  logic [4:0]        counter,
    output logic              R8,
    output logic              R9,
    output logic              R10,
    output logic              R11,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              blk_go,
    input  logic              core_done,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_next;
    logic [NBLK_W-1:0] r_nblk_q;
    logic              w_xfer;
    logic              w_last_word;
    logic              w_last_blk;
    logic [1:0]        w_sw_ctl;
    logic [1:0]        w_cnt_ctl;

    // Transfer is decoded from state rather than from word_valid so the
    // output process does not read back its own output.
    assign w_xfer      = (r_state == S_LOAD) && word_ready;
    assign w_last_word = (sw == 5'(NWORDS - 1));
    // r_nblk_q is at least 1 whenever NEXT is reachable.
    assign w_last_blk  = (int'(counter) == int'(r_nblk_q) - 1);

    assign {R8, R9}   = w_sw_ctl;
    assign {R10, R11} = w_cnt_ctl;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Block count is captured once per job; zero requests one block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nblk_q <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_nblk_q <= (nblocks == '0) ? NBLK_W'(1) : nblocks;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_CLR;
            S_CLR:  w_next = S_LOAD;
            S_LOAD: if (w_xfer && w_last_word) w_next = S_GO;
            S_GO:   w_next = S_WAIT;
            S_WAIT: if (core_done) w_next = S_NEXT;
            S_NEXT: w_next = w_last_blk ? S_FIN : S_LOAD;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: Moore everywhere except the sw increment in LOAD,
    // which follows the transfer in the same cycle.
    always_comb begin
        w_sw_ctl   = CTL_HOLD;
        w_cnt_ctl  = CTL_HOLD;
        word_valid = 1'b0;
        blk_go     = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        case (r_state)
            S_IDLE: busy = 1'b0;
            S_CLR: begin
                w_sw_ctl  = CTL_CLR;
                w_cnt_ctl = CTL_CLR;
            end
            S_LOAD: begin
                word_valid = 1'b1;
                if (w_xfer) w_sw_ctl = CTL_INC;
            end
            S_GO:   blk_go = 1'b1;
            S_WAIT: ;
            S_NEXT: begin
                // Next block reloads from word 0; on the last block the
                // counter is left holding its final index.
                if (!w_last_blk) begin
                    w_sw_ctl  = CTL_CLR;
                    w_cnt_ctl = CTL_INC;
                end
            end
            S_FIN:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_hashgen_ctrl.sv
// tb_hashgen_ctrl -- bench for hashgen_ctrl with a behavioural datapath
// register pair (sw, counter) and a behavioural compression core.
// Expected event stream per job: NWORDS word transfers with indices
// 0..NWORDS-1 then a blk_go carrying the block index, for each block,
// followed by a single done.
module tb_hashgen_ctrl;

    localparam int NW = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] nblocks = 5'd0;
    logic       word_ready = 1'b0;
    logic       inj_done = 1'b0;
    logic       core_pulse = 1'b0;
    logic       core_done;
    logic [4:0] sw_q = 5'd19;
    logic [4:0] cnt_q = 5'd27;
    logic       R8, R9, R10, R11;
    logic       word_valid, blk_go, busy, done;

    int core_delay = 3;
    int total = 0;
    int bad = 0;

    typedef struct {
        int kind;   // 0 word transfer, 1 blk_go, 2 done
        int val;
    } ev_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    ev_t  exp_q[$];
    chk_t chk_q[$];

    always #5 clk = ~clk;

    assign core_done = core_pulse | inj_done;

    hashgen_ctrl #(.NWORDS(NW), .NBLK_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .nblocks    (nblocks),
        .sw         (sw_q),
        .counter    (cnt_q),
        .R8         (R8),
        .R9         (R9),
        .R10        (R10),
        .R11        (R11),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .blk_go     (blk_go),
        .core_done  (core_done),
        .busy       (busy),
        .done       (done)
    );

    // Datapath register pair: 00 clear, 01 increment, 1x hold
    always @(posedge clk) begin
        case ({R8, R9})
            2'b00:   sw_q <= 5'd0;
            2'b01:   sw_q <= sw_q + 5'd1;
            default: sw_q <= sw_q;
        endcase
        case ({R10, R11})
            2'b00:   cnt_q <= 5'd0;
            2'b01:   cnt_q <= cnt_q + 5'd1;
            default: cnt_q <= cnt_q;
        endcase
    end

    // Core model: core_done pulses core_delay cycles after blk_go
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && blk_go) begin
                repeat (core_delay) @(posedge clk);
                #1 core_pulse = 1'b1;
                @(posedge clk);
                #1 core_pulse = 1'b0;
            end
        end
    end

    function automatic void post(input string n, input int a, input int e);
        chk_t c;
        c.name = n;
        c.act  = a;
        c.exp  = e;
        chk_q.push_back(c);
    endfunction

    function automatic void observe(input int k, input int v);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d, required none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                bad++;
                $display("FAIL event_seq: got kind=%0d val=%0d, required kind=%0d val=%0d",
                         k, v, e.kind, e.val);
            end
        end
    endfunction

    // Monitor: drains posted direct checks and compares observed events
    initial begin
        chk_t c;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                total++;
                if (c.act != c.exp) begin
                    bad++;
                    $display("FAIL %s: got %0d, required %0d", c.name, c.act, c.exp);
                end
            end
            if (rst_n) begin
                if (word_valid && word_ready) observe(0, int'(sw_q));
                if (blk_go) observe(1, int'(cnt_q));
                if (done) observe(2, 0);
            end
        end
    end

    // Reference model of one job's observable behaviour
    function automatic void push_job(input int n);
        int  nb;
        ev_t e;
        nb = (n == 0) ? 1 : n;
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < NW; w++) begin
                e.kind = 0;
                e.val  = w;
                exp_q.push_back(e);
            end
            e.kind = 1;
            e.val  = b;
            exp_q.push_back(e);
        end
        e.kind = 2;
        e.val  = 0;
        exp_q.push_back(e);
    endfunction

    function automatic logic rdy(input int mode, input int ph);
        case (mode)
            0:       return 1'b1;
            1:       return (ph % 3 == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic post_reset_values(input string tag);
        post({tag, "_word_valid"}, int'(word_valid), 0);
        post({tag, "_busy"}, int'(busy), 0);
        post({tag, "_ctl"}, int'({R8, R9, R10, R11}), 'b1010);
        post({tag, "_blk_go"}, int'(blk_go), 0);
        post({tag, "_done"}, int'(done), 0);
    endtask

    task automatic run_job(input int n, input int mode, input bit start_wait,
                           input int rst_sw, input int dly);
        int cyc = 0;
        int ph = 0;
        bit got = 0;
        bit aborted = 0;
        bit pend_start = 0;
        core_delay = dly;
        push_job(n);
        @(posedge clk);
        #1;
        nblocks = 5'(n);
        start = 1'b1;
        word_ready = rdy(mode, ph);
        ph++;
        @(posedge clk);
        #1;
        start = 1'b0;
        nblocks = 5'($urandom_range(0, 31));
        word_ready = rdy(mode, ph);
        ph++;
        while (!got && !aborted && cyc < 3000) begin
            @(negedge clk);
            if (cyc == 3) post("busy_mid_job", int'(busy), 1);
            if (done) got = 1;
            if (start_wait && blk_go) pend_start = 1;
            if (rst_sw >= 0 && word_valid && int'(sw_q) == rst_sw) begin
                #2 rst_n = 1'b0;
                exp_q.delete();
                #1;
                post_reset_values("async_rst");
                @(posedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
                aborted = 1;
            end else begin
                @(posedge clk);
                #1;
                word_ready = rdy(mode, ph);
                ph++;
                start = pend_start;
                pend_start = 0;
                cyc++;
            end
        end
        start = 1'b0;
        if (aborted) begin
            repeat (6) @(negedge clk);
            post("abort_busy", int'(busy), 0);
        end else if (!got) begin
            post("job_done_seen", int'(got), 1);
            rst_n = 1'b0;
            exp_q.delete();
            @(posedge clk);
            #1 rst_n = 1'b1;
        end else begin
            @(negedge clk);
            post("busy_after_done", int'(busy), 0);
            post("queue_empty", exp_q.size(), 0);
        end
    endtask

    initial begin
        #7;
        post_reset_values("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Stray core_done and word_ready while idle must do nothing
        word_ready = 1'b1;
        inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        post("idle_busy", int'(busy), 0);
        post("idle_word_valid", int'(word_valid), 0);

        run_job(1, 0, 0, -1, 3);    // single block
        run_job(3, 0, 0, -1, 3);    // three blocks
        run_job(1, 1, 0, -1, 2);    // word_ready 1,0,0 pattern
        run_job(0, 0, 1, -1, 2);    // zero blocks, start pulsed in WAIT
        run_job(2, 0, 0, 7, 3);     // reset during LOAD at sw=7
        run_job(1, 0, 0, -1, 3);    // fresh job after reset
        for (int i = 0; i < 6; i++) begin
            run_job($urandom_range(0, 4), 2, 1'($urandom_range(0, 1)), -1,
                    $urandom_range(1, 4));
        end

        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
